rotate_right_seq: RTL and testbench
===================================

# rotate_right_seq

Iterative right-rotator: accepts a WIDTH-bit word and a rotation amount over a valid/ready handshake, rotates the word right by one position per clock, then presents the result over a second valid/ready handshake. It is the inverse of the team's combinational rotate-left-by-one shifter. Feeding that shifter's output through this block with amount 1 restores the original word. It sits downstream of the shifter in the datapath and trades area for latency: one 1-bit rotator stage is reused instead of a log-depth mux tree.

## Interface
- WIDTH, 4, data width; power of two, ≥ 2
- AMT_W, 2, amount width; equals log2(WIDTH)
- clk  input  1  clock, rising-edge active
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  upstream offers in_data/in_amt
- in_ready  output  1  block can accept; high only in IDLE
- in_data  input  WIDTH  word to rotate
- in_amt  input  AMT_W  right-rotate amount, 0..WIDTH-1
- out_valid  output  1  out_data holds a finished result
- out_ready  input  1  downstream accepts the result
- out_data  output  WIDTH  rotated word
- busy  output  1  high in SHIFT or DONE

## Operation
- Reset: one clock; reset is asynchronous and active-low.
- State machine with three states: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: load data register from in_data and cnt from in_amt.
  - Next state is DONE if in_amt==0, else SHIFT.
- SHIFT:
  - Each edge: data <= {data[0], data[WIDTH-1:1]} and cnt <= cnt-1.
  - When cnt==1 at the edge, that shift is the last one and the next state is DONE.
- DONE:
  - out_valid=1 and out_data=data.
  - On out_ready: next state is IDLE and the data register is kept.
  - Without out_ready: hold state, and out_data stays stable.
- out_data is driven continuously from the data register. It is valid only while out_valid=1.
- in_valid is ignored outside IDLE, and in_data/in_amt are not sampled there.
- busy = (state != IDLE).
- Arithmetic:
  - cnt is AMT_W bits and never wraps below 0.
  - The rotation is exact modulo WIDTH. in_amt cannot express WIDTH or more.
- Reset asserted (rst_n=0), including mid-SHIFT or in DONE with a pending output:
  - Immediately go to IDLE.
  - data=0, cnt=0, out_valid=0, in_ready=1, busy=0.
  - Any in-flight transaction is discarded.
- The transition out of DONE on out_ready goes to IDLE, not directly to a new load.
- An in_valid held through DONE is accepted on the first edge after IDLE is reached.

## Timing
- Reset values (while rst_n=0 and until the first accepting edge):
  - in_ready=1, out_valid=0, out_data=0, busy=0.
- Accept edge E0. With N=in_amt:
  - out_valid rises in the cycle after edge E0+N.
  - N=0 gives out_valid in the cycle immediately following E0. N=3 gives it after E0+3.
- Output handshake completes on the edge where out_valid&&out_ready. out_valid falls in the following cycle.
- in_ready rises in the cycle after output completion. This guarantees at least one idle cycle between transactions.
- Minimum cycles per transaction, from accept edge to next accept edge, is N+2, given out_ready held high.
- All outputs are registered or decoded from registered state. There is no combinational path from in_* or out_ready to any output.

## Test plan
- Reset then idle: rst_n=0 for 2 cycles, then released.
  - Required: in_ready=1, out_valid=0, out_data=4'b0000, busy=0.
- Single rotate: in_data=4'b1010, in_amt=1, out_ready=1.
  - Required: out_valid one cycle after E0+1, out_data=4'b0101.
  - Then in_data=4'b0101, amt 1 → 4'b1010.
- Zero and max amount: in_data=4'b1010, in_amt=0 → out_data=4'b1010 with out_valid in the cycle after E0.
  - Then in_data=4'b0001, in_amt=3 → 4'b0010 after 3 shifts. The bench checks busy=1 throughout.
- Backpressure: in_data=4'b1100, amt 2, out_ready=0 for 5 cycles after out_valid.
  - Required: out_data=4'b0011 held stable and in_ready=0 throughout.
  - Then out_ready=1: out_valid falls next cycle and in_ready rises.
- Ignored input while busy: during SHIFT of 4'b1000/amt 3, drive in_valid=1 with in_data=4'b1111.
  - Required: result 4'b0001 unaffected.
  - The held 4'b1111 is accepted only after return to IDLE.
- Reset mid-operation: assert rst_n=0 asynchronously (not on a clock edge) during SHIFT of 4'b0110/amt 3.
  - Required: out_valid, busy and out_data go to 0 without waiting for a clock.
  - After release, a new transaction 4'b0110/amt 1 → 4'b0011.

Source files
------------

// File: rtl/rotate_right_seq.sv
// Iterative right-rotator: a single 1-bit rotate stage is reused once per clock,
// with valid/ready handshakes on both the load side and the result side.
module rotate_right_seq #(
    parameter int WIDTH = 4,
    parameter int AMT_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [AMT_W-1:0] in_amt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_r;
    logic [WIDTH-1:0] data_r;
    logic [AMT_W-1:0] cnt_r;
    logic             in_ready_r;
    logic             out_valid_r;
    logic             busy_r;

    function automatic logic [WIDTH-1:0] ror1(input logic [WIDTH-1:0] v);
        return {v[0], v[WIDTH-1:1]};
    endfunction

    // Handshake FSM; every output flag is registered alongside the state it decodes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            data_r      <= {WIDTH{1'b0}};
            cnt_r       <= {AMT_W{1'b0}};
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        data_r     <= in_data;
                        cnt_r      <= in_amt;
                        in_ready_r <= 1'b0;
                        busy_r     <= 1'b1;
                        if (in_amt == {AMT_W{1'b0}}) begin
                            state_r     <= DONE;
                            out_valid_r <= 1'b1;
                        end else begin
                            state_r     <= SHIFT;
                            out_valid_r <= 1'b0;
                        end
                    end else begin
                        state_r     <= IDLE;
                        in_ready_r  <= 1'b1;
                        out_valid_r <= 1'b0;
                        busy_r      <= 1'b0;
                    end
                end
                SHIFT: begin
                    // A zero count cannot arise here; it is treated as finished so cnt never wraps.
                    if (cnt_r == {AMT_W{1'b0}}) begin
                        state_r     <= DONE;
                        out_valid_r <= 1'b1;
                    end else begin
                        data_r <= ror1(data_r);
                        cnt_r  <= cnt_r - {{(AMT_W-1){1'b0}}, 1'b1};
                        if (cnt_r == {{(AMT_W-1){1'b0}}, 1'b1}) begin
                            state_r     <= DONE;
                            out_valid_r <= 1'b1;
                        end else begin
                            state_r     <= SHIFT;
                            out_valid_r <= 1'b0;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_r     <= IDLE;
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        busy_r      <= 1'b0;
                    end else begin
                        state_r     <= DONE;
                        out_valid_r <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_data  = data_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_rotate_right_seq.sv
// Directed bench for rotate_right_seq: a vector table of rotations with exact
// latency checks, plus hand sequences for backpressure, ignored input and reset.
module tb_rotate_right_seq;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_data;
    logic [1:0] in_amt;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_data;
    logic       busy;

    int n_vec;
    int n_bad;

    typedef struct {
        logic [3:0] d;
        logic [1:0] a;
        logic [3:0] e;
    } vec_t;

    vec_t vecs[9];

    rotate_right_seq #(.WIDTH(4), .AMT_W(2)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_amt   (in_amt),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // One complete transaction with out_ready held high; latency checked cycle by cycle.
    task automatic run_vec(input logic [3:0] d, input logic [1:0] a, input logic [3:0] e);
        @(negedge clk);
        chk("pre_in_ready", {31'd0, in_ready}, 32'd1);
        in_valid  = 1'b1;
        in_data   = d;
        in_amt    = a;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < int'(a); i++) begin
            chk("shift_out_valid", {31'd0, out_valid}, 32'd0);
            chk("shift_busy", {31'd0, busy}, 32'd1);
            chk("shift_in_ready", {31'd0, in_ready}, 32'd0);
            @(negedge clk);
        end
        chk("done_out_valid", {31'd0, out_valid}, 32'd1);
        chk("done_out_data", {28'd0, out_data}, {28'd0, e});
        chk("done_busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        chk("post_out_valid", {31'd0, out_valid}, 32'd0);
        chk("post_in_ready", {31'd0, in_ready}, 32'd1);
        chk("post_busy", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        vecs[0] = '{d: 4'b1010, a: 2'd1, e: 4'b0101};
        vecs[1] = '{d: 4'b0101, a: 2'd1, e: 4'b1010};
        vecs[2] = '{d: 4'b1010, a: 2'd0, e: 4'b1010};
        vecs[3] = '{d: 4'b0001, a: 2'd3, e: 4'b0010};
        vecs[4] = '{d: 4'b1100, a: 2'd2, e: 4'b0011};
        vecs[5] = '{d: 4'b1000, a: 2'd3, e: 4'b0001};
        vecs[6] = '{d: 4'b0111, a: 2'd1, e: 4'b1011};
        vecs[7] = '{d: 4'b1001, a: 2'd2, e: 4'b0110};
        vecs[8] = '{d: 4'b1110, a: 2'd3, e: 4'b1101};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 4'b0000;
        in_amt    = 2'd0;
        out_ready = 1'b0;

        // Reset held for two cycles
        repeat (2) begin
            @(negedge clk);
            chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
            chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
            chk("rst_out_data", {28'd0, out_data}, 32'd0);
            chk("rst_busy", {31'd0, busy}, 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_in_ready", {31'd0, in_ready}, 32'd1);
        chk("idle_out_valid", {31'd0, out_valid}, 32'd0);
        chk("idle_busy", {31'd0, busy}, 32'd0);

        for (int k = 0; k < 9; k++) begin
            run_vec(vecs[k].d, vecs[k].a, vecs[k].e);
        end

        // Backpressure: result must hold for five cycles with out_ready low
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 4'b1100;
        in_amt    = 2'd2;
        @(negedge clk);
        in_valid = 1'b0;
        begin
            int budget;
            budget = 0;
            while (out_valid !== 1'b1 && budget < 10) begin
                @(negedge clk);
                budget++;
            end
            chk("bp_wait_budget", {31'd0, (budget == 2) ? 1'b1 : 1'b0}, 32'd1);
        end
        repeat (5) begin
            chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_out_data", {28'd0, out_data}, {28'd0, 4'b0011});
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_rel_out_valid", {31'd0, out_valid}, 32'd0);
        chk("bp_rel_in_ready", {31'd0, in_ready}, 32'd1);

        // Ignored input while busy, then accepted after return to IDLE
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 4'b1000;
        in_amt   = 2'd3;
        @(negedge clk);
        in_data = 4'b1111;
        in_amt  = 2'd1;
        repeat (3) @(negedge clk);
        chk("ign_out_valid", {31'd0, out_valid}, 32'd1);
        chk("ign_out_data", {28'd0, out_data}, {28'd0, 4'b0001});
        @(negedge clk);
        chk("ign_idle_in_ready", {31'd0, in_ready}, 32'd1);
        chk("ign_idle_out_valid", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
        chk("held_busy", {31'd0, busy}, 32'd1);
        chk("held_in_ready", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        chk("held_out_valid", {31'd0, out_valid}, 32'd1);
        chk("held_out_data", {28'd0, out_data}, {28'd0, 4'b1111});
        @(negedge clk);

        // Asynchronous reset in the middle of a shift
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 4'b0110;
        in_amt   = 2'd3;
        @(negedge clk);
        in_valid = 1'b0;
        chk("ar_busy_before", {31'd0, busy}, 32'd1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_out_valid", {31'd0, out_valid}, 32'd0);
        chk("ar_busy", {31'd0, busy}, 32'd0);
        chk("ar_out_data", {28'd0, out_data}, 32'd0);
        chk("ar_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        run_vec(4'b0110, 2'd1, 4'b0011);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
